dds_tune_ctrl: RTL and testbench
================================

// Module: dds_tune_ctrl
// PURPOSE
//  Receiving end of the front-panel button strobes. Consumes the active-low freq/phase adjust strobes
//  (coarse/micro/nano add/sub, phase add/sub) and applies each one to the DDS frequency and phase words.
//  Each strobe is synchronised, falling-edge detected and auto-repeated while held. Every change is
//  committed to the DDS accumulator with a one-cycle update pulse. Sits between the button block and the
//  phase accumulator.
// PARAMETERS
//  ACC_W          32            width of freq/phase words
//  FREQ_INIT      32'd42950     freq word after reset (1 kHz @ 100 MHz)
//  FREQ_MIN       32'd0         lower clamp for freq word
//  FREQ_MAX       32'h7FFF_FFFF upper clamp for freq word (Nyquist)
//  STEP_COARSE    32'd4294967   coarse freq step (100 kHz)
//  STEP_MICRO     32'd42950     micro freq step (1 kHz)
//  STEP_NANO      32'd43        nano freq step (1 Hz)
//  PHASE_STEP     32'h4000_0000 phase step (90 deg)
//  REPEAT_DLY     5_000_000     held-low cycles before first auto-repeat
//  REPEAT_PER     1_000_000     cycles between auto-repeats
// PORTS
//  clk            in   1      system clock
//  reset          in   1      reset, synchronous, active-low
//  sw_add_n       in   1      coarse freq up, active low
//  sw_sub_n       in   1      coarse freq down, active low
//  sw_micro_add_n in   1      micro freq up
//  sw_micro_sub_n in   1      micro freq down
//  sw_nano_add_n  in   1      nano freq up
//  sw_nano_sub_n  in   1      nano freq down
//  ph_add_n       in   1      phase up
//  ph_sub_n       in   1      phase down
//  freq_word      out  ACC_W  committed frequency tuning word
//  phase_word     out  ACC_W  committed phase offset word
//  update         out  1      1-cycle pulse: words changed this cycle
//  sat            out  1      1-cycle pulse with update: freq result was clamped
//  busy           out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - freq_word=FREQ_INIT, phase_word=0; update, sat, busy=0.
//   - FSM->IDLE; pending cleared; sync flops set to 1; repeat counters cleared.
//   - Reset mid-CALC/COMMIT aborts with no update pulse.
//  Input path, per strobe
//   - 2-flop sync, then falling-edge detect -> request.
//   - Held low: another request after REPEAT_DLY cycles, then every REPEAT_PER cycles.
//   - Release (high) clears the counter.
//  Arbitration
//   - Simultaneous requests: one command is taken, fixed priority:
//     coarse > micro > nano > phase; add > sub.
//   - All other simultaneous requests are dropped.
//  FSM: IDLE -> CALC -> COMMIT -> IDLE
//   - IDLE:   take pending if valid, else an arbitrated request.
//   - CALC:   compute the next value in ACC_W+1 bits.
//   - COMMIT: register freq_word/phase_word, update=1.
//  Pending
//   - Requests arriving in CALC/COMMIT go to a one-deep pending register; the newer overwrites the older.
//   - Pending is serviced from IDLE on the next cycle.
//  Latency
//   - Raw input first sampled low at edge k -> update=1 in cycle after edge k+3.
//   - Back-to-back commits are spaced 3 cycles apart at minimum.
//  Arithmetic
//   - Freq add/sub is unsigned, clamped to [FREQ_MIN, FREQ_MAX]; sat=1 when the clamp fires.
//   - Result equal to the bound exactly: no sat.
//   - Phase add/sub wraps modulo 2^ACC_W and never asserts sat.
//   - A command that leaves a word unchanged (at clamp) still pulses update.
//  busy=1 in CALC and COMMIT.
// STRUCTURE
//  Package dds_pkg
//   - cmd_t enum: CMD_NONE, CMD_F_CO_UP/DN, CMD_F_MI_UP/DN, CMD_F_NA_UP/DN, CMD_PH_UP/DN.
//   - state_t enum: IDLE, CALC, COMMIT.
//   - Default step/limit constants.
//  Sub-module tune_edge_repeat (sync + edge detect + auto-repeat counter, params REPEAT_DLY/REPEAT_PER),
//  instantiated 8x. Arbiter, FSM and datapath live in the top level.
// TESTING (REPEAT_DLY=16, REPEAT_PER=8 in bench)
//  1 Reset -> freq_word=42950, phase_word=0, update=0, sat=0, busy=0.
//  2 sw_add_n low 3 cycles then high -> exactly one update, 4 cycles after first low;
//    freq_word=4337917.
//  3 ph_add_n pulsed 4x from phase 0 -> 0x40000000, 0x80000000, 0xC0000000, 0x00000000; sat never 1.
//  4 freq_word=10, sw_nano_sub_n pulse -> freq_word=0, sat=1 with update.
//    From 0x7FFFFFF0, sw_add_n pulse -> 0x7FFFFFFF, sat=1.
//  5 sw_micro_add_n held low 16+3*8 cycles from 42950 -> 4 updates; freq_word=214750.
//  6 sw_add_n and sw_nano_add_n fall in the same cycle -> only coarse applied (4337917);
//    reset pulled low during CALC -> no update, freq_word=42950.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default constants for the DDS tuning controller.
// Strobe index order is also the arbitration priority (lowest index wins).
package dds_pkg;

    localparam int          DDS_ACC_W       = 32;
    localparam int          NUM_SW          = 8;
    localparam logic [31:0] DDS_FREQ_INIT   = 32'd42950;
    localparam logic [31:0] DDS_FREQ_MIN    = 32'd0;
    localparam logic [31:0] DDS_FREQ_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] DDS_STEP_COARSE = 32'd4294967;
    localparam logic [31:0] DDS_STEP_MICRO  = 32'd42950;
    localparam logic [31:0] DDS_STEP_NANO   = 32'd43;
    localparam logic [31:0] DDS_PHASE_STEP  = 32'h4000_0000;
    localparam int          DDS_REPEAT_DLY  = 5_000_000;
    localparam int          DDS_REPEAT_PER  = 1_000_000;

    // Encoding is strobe index + 1 so the arbiter can cast directly.
    typedef enum logic [3:0] {
        CMD_NONE    = 4'd0,
        CMD_F_CO_UP = 4'd1,
        CMD_F_CO_DN = 4'd2,
        CMD_F_MI_UP = 4'd3,
        CMD_F_MI_DN = 4'd4,
        CMD_F_NA_UP = 4'd5,
        CMD_F_NA_DN = 4'd6,
        CMD_PH_UP   = 4'd7,
        CMD_PH_DN   = 4'd8
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/tune_edge_repeat.sv
// One button strobe: 2-flop sync, falling-edge detect and hold-to-repeat.
// req is a single-cycle pulse on the press and on every repeat.
module tune_edge_repeat #(
    parameter int REPEAT_DLY = 5_000_000,
    parameter int REPEAT_PER = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_n,
    output logic req
);

    localparam int CMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CW   = $clog2(CMAX + 1);

    logic          s1, s2, s3;
    logic          rpt;
    logic [CW-1:0] cnt;
    logic          fall, fire;

    assign fall = s3 & ~s2;
    // cnt holds cycles since the last request while the button stays low
    assign fire = ~s2 & ~s3 & (rpt ? (cnt == CW'(REPEAT_PER)) : (cnt == CW'(REPEAT_DLY)));
    assign req  = fall | fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            s3  <= 1'b1;
            cnt <= '0;
            rpt <= 1'b0;
        end else begin
            s1 <= sw_n;
            s2 <= s1;
            s3 <= s2;
            if (s2) begin
                cnt <= '0;
                rpt <= 1'b0;
            end else if (fall || fire) begin
                cnt <= CW'(1);
                rpt <= rpt | fire;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dds_tune_ctrl.sv
// Applies front-panel freq/phase strobes to the DDS tuning words.
// IDLE picks a command, CALC computes the clamped/wrapped result, COMMIT shows it with update.
module dds_tune_ctrl
    import dds_pkg::*;
#(
    parameter int               ACC_W       = DDS_ACC_W,
    parameter logic [ACC_W-1:0] FREQ_INIT   = ACC_W'(DDS_FREQ_INIT),
    parameter logic [ACC_W-1:0] FREQ_MIN    = ACC_W'(DDS_FREQ_MIN),
    parameter logic [ACC_W-1:0] FREQ_MAX    = ACC_W'(DDS_FREQ_MAX),
    parameter logic [ACC_W-1:0] STEP_COARSE = ACC_W'(DDS_STEP_COARSE),
    parameter logic [ACC_W-1:0] STEP_MICRO  = ACC_W'(DDS_STEP_MICRO),
    parameter logic [ACC_W-1:0] STEP_NANO   = ACC_W'(DDS_STEP_NANO),
    parameter logic [ACC_W-1:0] PHASE_STEP  = ACC_W'(DDS_PHASE_STEP),
    parameter int               REPEAT_DLY  = DDS_REPEAT_DLY,
    parameter int               REPEAT_PER  = DDS_REPEAT_PER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_add_n,
    input  logic             sw_sub_n,
    input  logic             sw_micro_add_n,
    input  logic             sw_micro_sub_n,
    input  logic             sw_nano_add_n,
    input  logic             sw_nano_sub_n,
    input  logic             ph_add_n,
    input  logic             ph_sub_n,
    output logic [ACC_W-1:0] freq_word,
    output logic [ACC_W-1:0] phase_word,
    output logic             update,
    output logic             sat,
    output logic             busy
);

    logic [NUM_SW-1:0] sw_n;
    logic [NUM_SW-1:0] req;

    assign sw_n = {ph_sub_n, ph_add_n, sw_nano_sub_n, sw_nano_add_n,
                   sw_micro_sub_n, sw_micro_add_n, sw_sub_n, sw_add_n};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        tune_edge_repeat #(
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_ter (
            .clk  (clk),
            .reset(reset),
            .sw_n (sw_n[g]),
            .req  (req[g])
        );
    end

    // Fixed priority: lowest strobe index wins, the rest are dropped.
    cmd_t arb_cmd;
    always_comb begin
        arb_cmd = CMD_NONE;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (req[i]) arb_cmd = cmd_t'(4'(i + 1));
        end
    end

    state_t state, state_nxt;
    cmd_t   take_cmd, cur_cmd, pend_cmd;
    logic   load, pend_vld;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_cmd  = CMD_NONE;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    take_cmd  = pend_cmd;
                    load      = 1'b1;
                    state_nxt = CALC;
                end else if (arb_cmd != CMD_NONE) begin
                    take_cmd  = arb_cmd;
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request that cannot be taken right now parks here; newest wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_vld <= 1'b0;
            pend_cmd <= CMD_NONE;
            cur_cmd  <= CMD_NONE;
        end else begin
            if (arb_cmd != CMD_NONE && (state != IDLE || pend_vld)) begin
                pend_vld <= 1'b1;
                pend_cmd <= arb_cmd;
            end else if (state == IDLE && pend_vld) begin
                pend_vld <= 1'b0;
            end
            if (load) cur_cmd <= take_cmd;
        end
    end

    logic [ACC_W-1:0] step, f_nxt, p_nxt;
    logic [ACC_W:0]   sum, diff;
    logic             sat_nxt;

    assign sum  = {1'b0, freq_word} + {1'b0, step};
    assign diff = {1'b0, freq_word} - {1'b0, step};

    always_comb begin
        step    = '0;
        f_nxt   = freq_word;
        p_nxt   = phase_word;
        sat_nxt = 1'b0;
        case (cur_cmd)
            CMD_F_CO_UP, CMD_F_CO_DN: step = STEP_COARSE;
            CMD_F_MI_UP, CMD_F_MI_DN: step = STEP_MICRO;
            CMD_F_NA_UP, CMD_F_NA_DN: step = STEP_NANO;
            default:                  step = PHASE_STEP;
        endcase
        case (cur_cmd)
            CMD_F_CO_UP, CMD_F_MI_UP, CMD_F_NA_UP: begin
                if (sum > {1'b0, FREQ_MAX}) begin
                    f_nxt   = FREQ_MAX;
                    sat_nxt = 1'b1;
                end else begin
                    f_nxt = sum[ACC_W-1:0];
                end
            end
            CMD_F_CO_DN, CMD_F_MI_DN, CMD_F_NA_DN: begin
                // borrow out means the true result went below zero
                if (diff[ACC_W] || diff[ACC_W-1:0] < FREQ_MIN) begin
                    f_nxt   = FREQ_MIN;
                    sat_nxt = 1'b1;
                end else begin
                    f_nxt = diff[ACC_W-1:0];
                end
            end
            CMD_PH_UP: p_nxt = phase_word + PHASE_STEP;
            CMD_PH_DN: p_nxt = phase_word - PHASE_STEP;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            freq_word  <= FREQ_INIT;
            phase_word <= '0;
            update     <= 1'b0;
            sat        <= 1'b0;
        end else begin
            update <= (state == CALC);
            sat    <= (state == CALC) && sat_nxt;
            if (state == CALC) begin
                freq_word  <= f_nxt;
                phase_word <= p_nxt;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Directed bench for dds_tune_ctrl; two extra instances start near the freq clamps.
module tb_dds_tune_ctrl;

    localparam int IX_ADD = 0, IX_SUB = 1, IX_MI_ADD = 2, IX_MI_SUB = 3;
    localparam int IX_NA_ADD = 4, IX_NA_SUB = 5, IX_PH_ADD = 6, IX_PH_SUB = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sw_n = 8'hFF;
    logic [7:0]  sw_b = 8'hFF;
    logic [31:0] freq_word, phase_word, freq_lo, phase_lo, freq_hi, phase_hi;
    logic        update, sat, busy, upd_lo, sat_lo, busy_lo, upd_hi, sat_hi, busy_hi;

    int checks = 0, failures = 0;
    int upd_cnt = 0, sat_cnt = 0, upd_lo_cnt = 0, sat_lo_cnt = 0, sat_hi_cnt = 0;

    always #5 clk = ~clk;

    dds_tune_ctrl #(.REPEAT_DLY(16), .REPEAT_PER(8)) dut (
        .clk(clk), .reset(reset),
        .sw_add_n(sw_n[0]), .sw_sub_n(sw_n[1]),
        .sw_micro_add_n(sw_n[2]), .sw_micro_sub_n(sw_n[3]),
        .sw_nano_add_n(sw_n[4]), .sw_nano_sub_n(sw_n[5]),
        .ph_add_n(sw_n[6]), .ph_sub_n(sw_n[7]),
        .freq_word(freq_word), .phase_word(phase_word),
        .update(update), .sat(sat), .busy(busy)
    );

    dds_tune_ctrl #(.FREQ_INIT(32'd10), .REPEAT_DLY(16), .REPEAT_PER(8)) dut_lo (
        .clk(clk), .reset(reset),
        .sw_add_n(sw_b[0]), .sw_sub_n(sw_b[1]),
        .sw_micro_add_n(sw_b[2]), .sw_micro_sub_n(sw_b[3]),
        .sw_nano_add_n(sw_b[4]), .sw_nano_sub_n(sw_b[5]),
        .ph_add_n(sw_b[6]), .ph_sub_n(sw_b[7]),
        .freq_word(freq_lo), .phase_word(phase_lo),
        .update(upd_lo), .sat(sat_lo), .busy(busy_lo)
    );

    dds_tune_ctrl #(.FREQ_INIT(32'h7FFF_FFF0), .REPEAT_DLY(16), .REPEAT_PER(8)) dut_hi (
        .clk(clk), .reset(reset),
        .sw_add_n(sw_b[0]), .sw_sub_n(sw_b[1]),
        .sw_micro_add_n(sw_b[2]), .sw_micro_sub_n(sw_b[3]),
        .sw_nano_add_n(sw_b[4]), .sw_nano_sub_n(sw_b[5]),
        .ph_add_n(sw_b[6]), .ph_sub_n(sw_b[7]),
        .freq_word(freq_hi), .phase_word(phase_hi),
        .update(upd_hi), .sat(sat_hi), .busy(busy_hi)
    );

    always @(negedge clk) begin
        if (update) upd_cnt++;
        if (sat)    sat_cnt++;
        if (upd_lo) upd_lo_cnt++;
        if (sat_lo) sat_lo_cnt++;
        if (sat_hi) sat_hi_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        upd_cnt = 0; sat_cnt = 0; upd_lo_cnt = 0; sat_lo_cnt = 0; sat_hi_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        clr_cnt();
    endtask

    task automatic pulse(input int idx, input bit on_b);
        if (on_b) sw_b[idx] = 1'b0; else sw_n[idx] = 1'b0;
        tick();
        sw_n = 8'hFF;
        sw_b = 8'hFF;
    endtask

    // Bounded wait for the main instance's update pulse.
    task automatic wait_upd(input string tag);
        int n = 0;
        while (!update && n < 20) begin
            tick();
            n++;
        end
        chk(tag, update, 1'b1);
    endtask

    initial begin
        int first;
        do_reset();

        // reset state
        chk("rst_freq", freq_word, 32'd42950);
        chk("rst_phase", phase_word, 32'd0);
        chk("rst_update", update, 1'b0);
        chk("rst_sat", sat, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // coarse add held 3 cycles: one update, 4 edges after first low
        first = 0;
        sw_n[IX_ADD] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) sw_n[IX_ADD] = 1'b1;
            if (update && first == 0) first = i;
        end
        chk("co_latency", first, 4);
        chk("co_count", upd_cnt, 1);
        chk("co_freq", freq_word, 32'd4337917);

        // phase wraps through four quarter steps
        do_reset();
        pulse(IX_PH_ADD, 0); wait_upd("ph1_upd"); chk("ph1", phase_word, 32'h4000_0000);
        pulse(IX_PH_ADD, 0); wait_upd("ph2_upd"); chk("ph2", phase_word, 32'h8000_0000);
        pulse(IX_PH_ADD, 0); wait_upd("ph3_upd"); chk("ph3", phase_word, 32'hC000_0000);
        pulse(IX_PH_ADD, 0); wait_upd("ph4_upd"); chk("ph4", phase_word, 32'h0000_0000);
        chk("ph_sat_never", sat_cnt, 0);
        pulse(IX_PH_SUB, 0); wait_upd("phd_upd"); chk("ph_dn_wrap", phase_word, 32'hC000_0000);

        // micro sub lands exactly on the lower bound: no sat
        pulse(IX_MI_SUB, 0); wait_upd("mi_dn_upd");
        chk("mi_dn_exact", freq_word, 32'd0);
        chk("mi_dn_nosat", sat, 1'b0);
        // further nano sub stays at 0 but still updates, with sat
        pulse(IX_NA_SUB, 0); wait_upd("na_dn_upd");
        chk("na_dn_clamp", freq_word, 32'd0);
        chk("na_dn_sat", sat, 1'b1);

        // clamp instances: coarse add saturates only the high one
        clr_cnt();
        pulse(IX_ADD, 1);
        repeat (8) tick();
        chk("hi_co_freq", freq_hi, 32'h7FFF_FFFF);
        chk("hi_co_sat", sat_hi_cnt, 1);
        chk("lo_co_freq", freq_lo, 32'd4294977);
        chk("lo_co_nosat", sat_lo_cnt, 0);
        do_reset();
        pulse(IX_NA_SUB, 1);
        repeat (8) tick();
        chk("lo_na_freq", freq_lo, 32'd0);
        chk("lo_na_sat", sat_lo_cnt, 1);
        chk("lo_na_upd", upd_lo_cnt, 1);
        chk("hi_na_freq", freq_hi, 32'h7FFF_FFC5);
        chk("hi_na_nosat", sat_hi_cnt, 0);

        // auto-repeat: 16 + 3*8 cycles held gives 4 micro steps
        do_reset();
        sw_n[IX_MI_ADD] = 1'b0;
        repeat (40) tick();
        sw_n[IX_MI_ADD] = 1'b1;
        repeat (30) tick();
        chk("rep_count", upd_cnt, 4);
        chk("rep_freq", freq_word, 32'd214750);

        // simultaneous coarse + nano: only coarse applied
        do_reset();
        sw_n[IX_ADD] = 1'b0;
        sw_n[IX_NA_ADD] = 1'b0;
        tick();
        sw_n = 8'hFF;
        repeat (12) tick();
        chk("arb_count", upd_cnt, 1);
        chk("arb_freq", freq_word, 32'd4337917);

        // reset during CALC aborts the commit
        do_reset();
        pulse(IX_ADD, 0);
        tick();
        tick();
        chk("abort_busy", busy, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_upd_now", update, 1'b0);
        repeat (8) tick();
        chk("abort_count", upd_cnt, 0);
        chk("abort_freq", freq_word, 32'd42950);
        chk("abort_busy_end", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
